// File: rtl/load_store_unit.sv
// RISC-V style load/store unit for a 32-bit little-endian data memory.
// Sub-word stores take two cycles: a read-modify-write through a merge register.
//   state | meaning
//   IDLE  | accepts one request per cycle; loads, SW and errors finish in one cycle
//   RMW   | writes the merged word captured for a pending SB/SH
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {IDLE, RMW} state_t;

    state_t      state;
    logic [31:0] rmw_addr;
    logic [31:0] rmw_wdata;

    logic [1:0]  lane;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        illegal;
    logic        misaligned;
    logic        bad;
    logic [31:0] word_addr;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] merged;

    always_comb begin
        lane       = req_addr[1:0];
        word_addr  = {req_addr[31:2], 2'b00};
        is_byte    = (req_funct3[1:0] == 2'b00);
        is_half    = (req_funct3[1:0] == 2'b01);
        is_word    = (req_funct3[1:0] == 2'b10);
        // Stores only know 000/001/010; loads additionally allow the unsigned 100/101.
        illegal    = (req_funct3[1:0] == 2'b11) |
                     (req_write ? req_funct3[2] : (req_funct3 == 3'b110));
        misaligned = (is_half & lane[0]) | (is_word & (lane != 2'b00));
        bad        = illegal | misaligned;
    end

    always_comb begin
        shifted = mem_rdata >> {lane, 3'b000};
        case (req_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (is_byte) begin
            merged[{lane, 3'b000} +: 8] = req_wdata[7:0];
        end else begin
            merged[{lane[1], 4'b0000} +: 16] = req_wdata[15:0];
        end
    end

    // Memory-side strobes are combinational and forced quiet during reset.
    always_comb begin
        stall     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = word_addr;
        mem_wdata = req_wdata;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_valid && !bad) begin
                        if (!req_write) begin
                            mem_read = 1'b1;
                        end else if (is_word) begin
                            mem_write = 1'b1;
                        end else begin
                            mem_read = 1'b1;
                            stall    = 1'b1;
                        end
                    end
                end
                RMW: begin
                    mem_write = 1'b1;
                    mem_addr  = rmw_addr;
                    mem_wdata = rmw_wdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            resp_rdata <= 32'd0;
            rmw_addr   <= 32'd0;
            rmw_wdata  <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (bad) begin
                            resp_valid <= 1'b1;
                            err        <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (!req_write) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= load_data;
                        end else if (is_word) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            rmw_addr  <= word_addr;
                            rmw_wdata <= merged;
                            state     <= RMW;
                        end
                    end
                end
                RMW: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
